// File: rtl/digi_many_rr.sv
// rtl/digi_many_rr.sv - round-robin framing aggregator of CHAN channel buffers into one output FIFO
// Optional trailer word (XOR of the event payload) enabled by defining DIGI_TRAILER_EN.
module digi_many_rr #(
  parameter int CHAN  = 8,
  parameter int WIDTH = 16,
  parameter int SIZE  = 8,
  parameter int DEPTH = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CHAN-1:0]          CH_READY,
  output logic [CHAN-1:0]          CH_RD,
  input  logic [WIDTH*CHAN-1:0]    CH_DOUT,
  output logic [CHAN-1:0]          CH_DONE,
  input  logic [SIZE-1:0]          HOWMANY,
  input  logic                     RD_EN,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     BUSY
);
  localparam int CHW = $clog2(CHAN);
  localparam int BCW = WIDTH - 1 - CHW;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [CW-1:0] THROTTLE = CW'(DEPTH - 2);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_TRAILER, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CHW-1:0]   ptr, ch_q, gnt, cand;
  logic [BCW-1:0]   bc, bc_q;
  logic [SIZE-1:0]  cnt;
  logic             rd_q, rd_issue, any_req;
  logic             fifo_wr;
  logic [WIDTH-1:0] fifo_wdata, ch_data;
  logic [WIDTH-1:0] ch_words [CHAN];

  for (genvar g = 0; g < CHAN; g++) begin : g_split
    assign ch_words[g] = CH_DOUT[g*WIDTH +: WIDTH];
  end
  assign ch_data = ch_words[ch_q];

  // First requesting channel at or after ptr, scanning circularly
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    cand    = '0;
    for (int i = 0; i < CHAN; i++) begin
      cand = CHW'((int'(ptr) + i) % CHAN);
      if (!any_req && CH_READY[cand]) begin
        any_req = 1'b1;
        gnt     = cand;
      end
    end
  end

`ifdef DIGI_TRAILER_EN
  localparam state_t S_END = S_TRAILER;
  logic [WIDTH-1:0] xor_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          xor_q <= '0;
    else if (state == S_IDLE)         xor_q <= '0;
    else if (state == S_PAYLOAD && rd_q) xor_q <= xor_q ^ ch_data;
  end
`else
  localparam state_t S_END = S_DONE;
`endif

  always_comb begin
    state_nx   = state;
    CH_RD      = '0;
    CH_DONE    = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    rd_issue   = 1'b0;
    case (state)
      S_IDLE: if (any_req) state_nx = S_HEADER;
      S_HEADER: begin
        if (!FULL) begin
          fifo_wr    = 1'b1;
          fifo_wdata = {1'b1, ch_q, bc_q};
          state_nx   = (cnt != '0) ? S_PAYLOAD : S_END;
        end
      end
      S_PAYLOAD: begin
        if (rd_q) begin
          fifo_wr    = 1'b1;
          fifo_wdata = ch_data;
        end
        // cnt==0 here means the last read is landing on this edge
        if (cnt != '0) begin
          if (COUNT <= THROTTLE) begin
            rd_issue    = 1'b1;
            CH_RD[ch_q] = 1'b1;
          end
        end else begin
          state_nx = S_END;
        end
      end
`ifdef DIGI_TRAILER_EN
      S_TRAILER: begin
        if (!FULL) begin
          fifo_wr    = 1'b1;
          fifo_wdata = xor_q;
          state_nx   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        CH_DONE[ch_q] = 1'b1;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      ptr   <= '0;
      ch_q  <= '0;
      bc    <= '0;
      bc_q  <= '0;
      cnt   <= '0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nx;
      bc    <= bc + BCW'(1);
      rd_q  <= rd_issue;
      if (state == S_IDLE && any_req) begin
        ch_q <= gnt;
        bc_q <= bc;
        cnt  <= HOWMANY;
        ptr  <= (gnt == CHW'(CHAN - 1)) ? '0 : gnt + CHW'(1);
      end
      if (rd_issue) cnt <= cnt - SIZE'(1);
    end
  end

  assign BUSY = (state != S_IDLE);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en, rd_en;

  assign wr_en = fifo_wr && !FULL;
  assign rd_en = RD_EN && !EMPTY;
  assign FULL  = (count == FULL_LVL);
  assign EMPTY = (count == '0);
  assign COUNT = count;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= fifo_wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      DOUT   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        DOUT   <= mem[rd_ptr];
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
